// File: rtl/interval_counter_pkg.sv
// Shared types and default sizing for the interval counter.
package interval_counter_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_PS_W  = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/interval_counter_if.sv
// Control/status bundle of the interval counter; master drives the controls.
interface interval_counter_if #(
    parameter int unsigned WIDTH = interval_counter_pkg::DEF_WIDTH,
    parameter int unsigned PS_W  = interval_counter_pkg::DEF_PS_W
);
    logic             Start;
    logic             Stop;
    logic             Periodic;
    logic             Down;
    logic [WIDTH-1:0] Limit;
    logic [PS_W-1:0]  Prescale;
    logic [WIDTH-1:0] Count;
    logic             Busy;
    logic             Done;

    modport master (
        output Start, Stop, Periodic, Down, Limit, Prescale,
        input  Count, Busy, Done
    );

    modport slave (
        input  Start, Stop, Periodic, Down, Limit, Prescale,
        output Count, Busy, Done
    );
endinterface

// File: rtl/interval_prescaler.sv
// Clock divider: tick fires on the clock where the phase counter reaches period.
module interval_prescaler
    import interval_counter_pkg::*;
#(
    parameter int unsigned PS_W = DEF_PS_W
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic            clear,
    input  logic            enable,
    input  logic [PS_W-1:0] period,
    output logic            tick
);

    logic [PS_W-1:0] phase_q;

    // Combinational so the owning FSM acts on the same edge the phase wraps.
    assign tick = enable && (phase_q == period);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            phase_q <= '0;
        end else if (clear) begin
            phase_q <= '0;
        end else if (enable) begin
            phase_q <= tick ? '0 : phase_q + PS_W'(1);
        end
    end

endmodule

// File: rtl/interval_counter.sv
// Prescaled up/down interval counter with one-shot or auto-reload operation.
module interval_counter
    import interval_counter_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned PS_W  = DEF_PS_W
) (
    input  logic               Clock,
    input  logic               Reset,
    interval_counter_if.slave  bus
);

    state_t           state_q;
    logic [WIDTH-1:0] count_q;
    logic             busy_q;
    logic             done_q;
    logic             periodic_q;
    logic             down_q;
    logic [WIDTH-1:0] limit_q;
    logic [PS_W-1:0]  prescale_q;

    logic             tick;
    logic             start_req;
    logic             ps_clear;
    logic             ps_enable;
    logic [WIDTH-1:0] terminal;
    logic [WIDTH-1:0] reload;

    // Stop dominates a simultaneous Start.
    assign start_req = bus.Start && !bus.Stop;
    assign ps_clear  = bus.Start || bus.Stop;
    assign ps_enable = (state_q == RUN);
    assign terminal  = down_q ? '0 : limit_q;
    assign reload    = down_q ? limit_q : '0;

    interval_prescaler #(.PS_W(PS_W)) u_prescaler (
        .Clock  (Clock),
        .Reset  (Reset),
        .clear  (ps_clear),
        .enable (ps_enable),
        .period (prescale_q),
        .tick   (tick)
    );

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            periodic_q <= 1'b0;
            down_q     <= 1'b0;
            limit_q    <= '0;
            prescale_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_req) begin
                        periodic_q <= bus.Periodic;
                        down_q     <= bus.Down;
                        limit_q    <= bus.Limit;
                        prescale_q <= bus.Prescale;
                        count_q    <= bus.Down ? bus.Limit : '0;
                        state_q    <= RUN;
                        busy_q     <= 1'b1;
                    end
                end
                RUN: begin
                    if (bus.Stop) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (bus.Start) begin
                        // Restart re-latches everything and never reports Done.
                        periodic_q <= bus.Periodic;
                        down_q     <= bus.Down;
                        limit_q    <= bus.Limit;
                        prescale_q <= bus.Prescale;
                        count_q    <= bus.Down ? bus.Limit : '0;
                    end else if (tick) begin
                        if (count_q == terminal) begin
                            done_q <= 1'b1;
                            if (periodic_q) begin
                                count_q <= reload;
                            end else begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                            end
                        end else begin
                            count_q <= down_q ? count_q - WIDTH'(1) : count_q + WIDTH'(1);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Count = count_q;
    assign bus.Busy  = busy_q;
    assign bus.Done  = done_q;

endmodule

// File: tb/tb_interval_counter.sv
// Self-checking bench: vector table, directed corner sequences, random vs model.
module tb_interval_counter;

    localparam int unsigned W  = 8;
    localparam int unsigned PW = 4;

    logic Clock = 1'b0;
    logic Reset;

    interval_counter_if #(.WIDTH(W), .PS_W(PW)) bus ();

    interval_counter #(.WIDTH(W), .PS_W(PW)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit st; bit sp; bit per; bit dn; int lim; int ps;
        int c;  bit b;  bit d;
    } vec_t;
    vec_t tbl[$];

    // Reference model state: run = Busy, n = clocks elapsed since the start edge.
    bit m_run, m_per, m_down, m_done;
    int m_lim, m_ps, m_n, m_count;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic expect3(input string name, input int c, input bit b, input bit d);
        check({name, "_count"}, int'(bus.Count), c);
        check({name, "_busy"},  int'(bus.Busy),  int'(b));
        check({name, "_done"},  int'(bus.Done),  int'(d));
    endtask

    task automatic drive(input bit st, input bit sp, input bit per, input bit dn,
                         input int lim, input int ps);
        bus.Start    = st;
        bus.Stop     = sp;
        bus.Periodic = per;
        bus.Down     = dn;
        bus.Limit    = W'(lim);
        bus.Prescale = PW'(ps);
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    function automatic void add(input bit st, input bit sp, input bit per, input bit dn,
                                input int lim, input int ps, input int c, input bit b, input bit d);
        vec_t v;
        v.st = st; v.sp = sp; v.per = per; v.dn = dn; v.lim = lim; v.ps = ps;
        v.c = c; v.b = b; v.d = d;
        tbl.push_back(v);
    endfunction

    function automatic void model_reset();
        m_run = 0; m_per = 0; m_down = 0; m_done = 0;
        m_lim = 0; m_ps = 0; m_n = 0; m_count = 0;
    endfunction

    // Count after k ticks is position k mod (Limit+1) within the period.
    function automatic void model_step(input bit st, input bit sp, input bit per, input bit dn,
                                       input int lim, input int ps);
        int k, pos;
        m_done = 0;
        if (m_run && sp) begin
            m_run = 0;
        end else if (st && !sp) begin
            m_per = per; m_down = dn; m_lim = lim; m_ps = ps;
            m_n = 0; m_run = 1;
            m_count = dn ? lim : 0;
        end else if (m_run) begin
            m_n++;
            if (m_n % (m_ps + 1) == 0) begin
                k   = m_n / (m_ps + 1);
                pos = k % (m_lim + 1);
                if (pos == 0) begin
                    m_done = 1;
                    if (!m_per) m_run = 0;
                    else m_count = m_down ? m_lim : 0;
                end else begin
                    m_count = m_down ? m_lim - pos : pos;
                end
            end
        end
    endfunction

    task automatic oneshot_up3(input string name);
        drive(1, 0, 0, 0, 3, 0); step(); expect3({name, "_s"}, 0, 1, 0);
        drive(0, 0, 1, 1, 77, 9);
        step(); expect3({name, "_1"}, 1, 1, 0);
        step(); expect3({name, "_2"}, 2, 1, 0);
        step(); expect3({name, "_3"}, 3, 1, 0);
        step(); expect3({name, "_t"}, 3, 0, 1);
        step(); expect3({name, "_h"}, 3, 0, 0);
    endtask

    initial begin
        int lim, ps;
        bit st, sp, per, dn;

        // Up one-shot L=3 P=0; non-start rows carry junk config that must be ignored.
        add(1,0,0,0,3,0, 0,1,0);
        add(0,0,1,1,99,7, 1,1,0);
        add(0,0,1,1,99,7, 2,1,0);
        add(0,0,0,1,50,2, 3,1,0);
        add(0,0,0,0,1,0,  3,0,1);
        add(0,1,1,0,8,0,  3,0,0);
        // Down periodic L=2 P=1.
        add(1,0,1,1,2,1, 2,1,0);
        for (int r = 0; r < 2; r++) begin
            add(0,0,0,0,200,0, 2,1,0);
            add(0,0,0,0,200,0, 1,1,0);
            add(0,0,0,0,200,0, 1,1,0);
            add(0,0,0,0,200,0, 0,1,0);
            add(0,0,0,0,200,0, 0,1,0);
            add(0,0,0,0,200,0, 2,1,1);
        end
        add(0,1,0,0,0,0, 2,0,0);
        // Up periodic L=0 P=3.
        add(1,0,1,0,0,3, 0,1,0);
        for (int r = 0; r < 2; r++) begin
            add(0,0,0,1,5,0, 0,1,0);
            add(0,0,0,1,5,0, 0,1,0);
            add(0,0,0,1,5,0, 0,1,0);
            add(0,0,0,1,5,0, 0,1,1);
        end
        add(0,1,0,0,0,0, 0,0,0);

        Reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        #12;
        expect3("reset", 0, 0, 0);
        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);

        foreach (tbl[i]) begin
            drive(tbl[i].st, tbl[i].sp, tbl[i].per, tbl[i].dn, tbl[i].lim, tbl[i].ps);
            step();
            expect3($sformatf("vec%0d", i), tbl[i].c, tbl[i].b, tbl[i].d);
        end

        // Stop exactly on the terminal tick suppresses Done.
        drive(1, 0, 0, 0, 5, 0); step(); expect3("stopterm_s", 0, 1, 0);
        drive(0, 0, 0, 0, 5, 0);
        for (int i = 1; i <= 5; i++) begin step(); expect3("stopterm_run", i, 1, 0); end
        drive(0, 1, 0, 0, 5, 0); step(); expect3("stopterm_edge", 5, 0, 0);
        drive(0, 0, 0, 0, 5, 0); step(); expect3("stopterm_after", 5, 0, 0);
        drive(0, 1, 0, 0, 5, 0); step(); expect3("stop_idle", 5, 0, 0);
        drive(1, 1, 0, 1, 9, 0); step(); expect3("startstop_idle", 5, 0, 0);
        drive(1, 0, 0, 0, 5, 0); step(); expect3("ss_run_s", 0, 1, 0);
        drive(0, 0, 0, 0, 5, 0); step(); expect3("ss_run_1", 1, 1, 0);
        drive(1, 1, 0, 1, 9, 0); step(); expect3("startstop_run", 1, 0, 0);

        // Restart at Count=4 must reload and clear the prescaler phase.
        drive(1, 0, 0, 0, 9, 1); step(); expect3("restart_s", 0, 1, 0);
        drive(0, 0, 0, 0, 9, 1);
        for (int i = 1; i <= 8; i++) begin step(); expect3("restart_run", i / 2, 1, 0); end
        drive(1, 0, 0, 0, 9, 1); step(); expect3("restart_edge", 0, 1, 0);
        drive(0, 0, 0, 0, 9, 1); step(); expect3("restart_ps0", 0, 1, 0);
        step(); expect3("restart_ps1", 1, 1, 0);
        drive(0, 1, 0, 0, 0, 0); step();

        // Async reset between edges, then recovery.
        drive(1, 0, 0, 0, 3, 0); step();
        drive(0, 0, 0, 0, 3, 0); step(); step();
        #2 Reset = 1'b0;
        #1 expect3("async_reset", 0, 0, 0);
        step(); expect3("reset_held", 0, 0, 0);
        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        oneshot_up3("recover");

        // Randomized run against the model.
        Reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        #3;
        model_reset();
        @(negedge Clock);
        Reset = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            st  = ($urandom_range(0, 15) == 0);
            sp  = ($urandom_range(0, 39) == 0);
            per = 1'($urandom_range(0, 1));
            dn  = 1'($urandom_range(0, 1));
            lim = ($urandom_range(0, 9) < 7) ? int'($urandom_range(0, 6)) : int'($urandom_range(0, 255));
            ps  = ($urandom_range(0, 3) < 3) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 15));
            @(negedge Clock);
            drive(st, sp, per, dn, lim, ps);
            model_step(st, sp, per, dn, lim, ps);
            step();
            expect3("rand", m_count, m_run, m_done);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
